// File: rtl/rf_writeback_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : rf_writeback_buffer_if
//  Description : Producer/consumer bundle for the register-file write-back
//                buffer: memory-stage and ALU result handshakes, the register
//                file write port, and the two forwarding lookups.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rf_writeback_buffer_if #(
  parameter int N  = 32,
  parameter int AW = 5
);
  logic          mem_valid;
  logic [AW-1:0] mem_rd;
  logic [N-1:0]  mem_data;
  logic          mem_ready;

  logic          alu_valid;
  logic [AW-1:0] alu_rd;
  logic [N-1:0]  alu_data;
  logic          alu_ready;

  logic          rf_we;
  logic [AW-1:0] rf_rd;
  logic [N-1:0]  rf_wdata;

  logic [AW-1:0] q_rs1;
  logic [AW-1:0] q_rs2;
  logic          fwd1_hit;
  logic [N-1:0]  fwd1_data;
  logic          fwd2_hit;
  logic [N-1:0]  fwd2_data;

  // Pipeline side: presents results and lookup addresses.
  modport master (
    output mem_valid, mem_rd, mem_data,
    output alu_valid, alu_rd, alu_data,
    output q_rs1, q_rs2,
    input  mem_ready, alu_ready,
    input  rf_we, rf_rd, rf_wdata,
    input  fwd1_hit, fwd1_data, fwd2_hit, fwd2_data
  );

  // Buffer side: accepts results, drives the write port and forwarding.
  modport slave (
    input  mem_valid, mem_rd, mem_data,
    input  alu_valid, alu_rd, alu_data,
    input  q_rs1, q_rs2,
    output mem_ready, alu_ready,
    output rf_we, rf_rd, rf_wdata,
    output fwd1_hit, fwd1_data, fwd2_hit, fwd2_data
  );
endinterface
`default_nettype wire

// File: rtl/rf_writeback_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : rf_writeback_buffer
//  Description : In-order write-back queue in front of the 32x32 register
//                file. Accepts up to two results per cycle (memory result is
//                the older one), retires one write per cycle, drops writes to
//                x0, and forwards the youngest pending value for two reads.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_writeback_buffer #(
  parameter int N     = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int CW    = 3
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  rf_writeback_buffer_if.slave wb,
  output logic [CW-1:0]      count,
  output logic               busy
);

  localparam int            c_PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] c_DEPTH_M1 = CW'(DEPTH - 1);
  localparam logic [CW-1:0] c_DEPTH_M2 = CW'(DEPTH - 2);
  localparam logic [AW-1:0] c_X0       = '0;

  // Queue storage; r_vld marks occupied slots so forwarding never sees
  // stale contents of slots that have already retired.
  logic [AW-1:0]    r_rd   [DEPTH];
  logic [N-1:0]     r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [c_PW-1:0]  r_head;
  logic [c_PW-1:0]  r_tail;
  logic [CW-1:0]    r_count;

  logic             w_mem_ready;
  logic             w_alu_ready;
  logic             w_mem_enq;
  logic             w_alu_enq;
  logic             w_pop;
  logic [c_PW-1:0]  w_alu_slot;
  logic [c_PW-1:0]  w_tail_next;
  logic [CW-1:0]    w_count_next;
  logic [DEPTH-1:0] w_vld_next;
  logic [c_PW-1:0]  w_scan_idx;
  logic             w_hit1;
  logic             w_hit2;
  logic [N-1:0]     w_fdata1;
  logic [N-1:0]     w_fdata2;

  // Admission control from the registered count only; the same-cycle pop
  // is not credited. Both readies drop while reset is held.
  always_comb begin
    w_mem_ready = rst_n && (r_count <= c_DEPTH_M1);
    w_alu_ready = rst_n && ((r_count <= c_DEPTH_M2) ||
                            ((r_count <= c_DEPTH_M1) && !wb.mem_valid));
  end

  // Enqueue/pop decisions and next-state pointer/count arithmetic. Writes to
  // x0 complete the handshake but never occupy a slot.
  always_comb begin
    w_mem_enq    = wb.mem_valid && w_mem_ready && (wb.mem_rd != c_X0);
    w_alu_enq    = wb.alu_valid && w_alu_ready && (wb.alu_rd != c_X0);
    w_pop        = (r_count != '0);
    w_alu_slot   = r_tail + c_PW'(w_mem_enq);
    w_tail_next  = w_alu_slot + c_PW'(w_alu_enq);
    w_count_next = r_count + CW'(w_mem_enq) + CW'(w_alu_enq) - CW'(w_pop);
    w_vld_next   = r_vld;
    if (w_pop) begin
      w_vld_next[r_head] = 1'b0;
    end
    if (w_mem_enq) begin
      w_vld_next[r_tail] = 1'b1;
    end
    if (w_alu_enq) begin
      w_vld_next[w_alu_slot] = 1'b1;
    end
  end

  // Pointer, count and occupancy state; reset discards every pending entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else begin
      r_head  <= w_pop ? (r_head + c_PW'(1)) : r_head;
      r_tail  <= w_tail_next;
      r_count <= w_count_next;
      r_vld   <= w_vld_next;
    end
  end

  // Payload storage; the memory result lands first so it retires first.
  always_ff @(posedge clk) begin
    if (w_mem_enq) begin
      r_rd[r_tail]   <= wb.mem_rd;
      r_data[r_tail] <= wb.mem_data;
    end
    if (w_alu_enq) begin
      r_rd[w_alu_slot]   <= wb.alu_rd;
      r_data[w_alu_slot] <= wb.alu_data;
    end
  end

  // Forwarding scan from oldest to youngest so later matches overwrite
  // earlier ones; the head being written this cycle is still searched.
  always_comb begin
    w_scan_idx = '0;
    w_hit1     = 1'b0;
    w_hit2     = 1'b0;
    w_fdata1   = '0;
    w_fdata2   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_scan_idx = r_head + c_PW'(i);
      if (r_vld[w_scan_idx] && (wb.q_rs1 != c_X0) &&
          (r_rd[w_scan_idx] == wb.q_rs1)) begin
        w_hit1   = 1'b1;
        w_fdata1 = r_data[w_scan_idx];
      end
      if (r_vld[w_scan_idx] && (wb.q_rs2 != c_X0) &&
          (r_rd[w_scan_idx] == wb.q_rs2)) begin
        w_hit2   = 1'b1;
        w_fdata2 = r_data[w_scan_idx];
      end
    end
  end

  assign wb.mem_ready = w_mem_ready;
  assign wb.alu_ready = w_alu_ready;

  // The register file writes the head every cycle the queue is non-empty.
  assign wb.rf_we     = w_pop;
  assign wb.rf_rd     = w_pop ? r_rd[r_head]   : '0;
  assign wb.rf_wdata  = w_pop ? r_data[r_head] : '0;

  assign wb.fwd1_hit  = w_hit1;
  assign wb.fwd1_data = w_fdata1;
  assign wb.fwd2_hit  = w_hit2;
  assign wb.fwd2_data = w_fdata2;

  assign count = r_count;
  assign busy  = w_pop;

endmodule
`default_nettype wire
